// File: rtl/boot_load_ctrl.sv
// boot_load_ctrl: boot sequencer and program-memory port arbiter.
//
// After reset the controller pulls a length-prefixed image from the SPI flash
// interface. It writes each word to memory starting at LOAD_BASE, then checks
// the XOR checksum word that follows the image. While it is loading it owns the
// memory port and stalls the CPU. After a good load (or boot_skip) it passes the
// CPU port straight through to memory with zero latency. A failed load parks in
// ERR and keeps the CPU stalled until the next reset.
//
// Optional feature: define BOOT_TIMEOUT_EN to enable the SPI response timeout.
// A request that stays unacknowledged for TIMEOUT_CYC cycles then ends in ERR
// with code 3.
//
// Ports:
//   clk, rst            clock; synchronous active-low reset
//   boot_skip           sampled in IDLE, 1 = go straight to DONE
//   spi_req/ack/rdata   word request handshake to the flash reader
//   cpu_cs/we/addr/din  CPU memory request (used only after boot_done)
//   mem_cs/we/addr/din  program memory port
//   cpu_stall           1 while the CPU must hold
//   boot_done, boot_err completion / sticky failure flags
//   err_code            0 none, 1 length too big, 2 checksum, 3 timeout
module boot_load_ctrl #(
    parameter int unsigned       ADDR_W      = 12,
    parameter logic [ADDR_W-1:0] LOAD_BASE   = ADDR_W'(12'h010),
    parameter int unsigned       MAX_WORDS   = 256,
    parameter int unsigned       TIMEOUT_CYC = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              boot_skip,
    output logic              spi_req,
    input  logic              spi_ack,
    input  logic [15:0]       spi_rdata,
    input  logic              cpu_cs,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [15:0]       cpu_din,
    output logic              mem_cs,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_din,
    output logic              cpu_stall,
    output logic              boot_done,
    output logic              boot_err,
    output logic [1:0]        err_code
);

    localparam int unsigned DW = 16;
    localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);

`ifdef BOOT_TIMEOUT_EN
    localparam bit TIMEOUT_ON = 1'b1;
`else
    localparam bit TIMEOUT_ON = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ_LEN,
        S_REQ_DATA,
        S_WRITE,
        S_REQ_SUM,
        S_DONE,
        S_ERR
    } state_t;

    state_t            state_q, state_d;
    logic [DW-1:0]     len_q, len_d;
    logic [DW-1:0]     idx_q, idx_d;
    logic [DW-1:0]     sum_q, sum_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              spi_req_q, spi_req_d;
    logic              mem_wr_q, mem_wr_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0]     mem_din_q, mem_din_d;
    logic              stall_q, stall_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [1:0]        code_q, code_d;
    logic              is_req;
    logic              timeout_hit;

    // State, datapath and registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            idx_q      <= '0;
            sum_q      <= '0;
            cnt_q      <= '0;
            spi_req_q  <= 1'b0;
            mem_wr_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            stall_q    <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            code_q     <= 2'd0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            sum_q      <= sum_d;
            cnt_q      <= cnt_d;
            spi_req_q  <= spi_req_d;
            mem_wr_q   <= mem_wr_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
            stall_q    <= stall_d;
            done_q     <= done_d;
            err_q      <= err_d;
            code_q     <= code_d;
        end
    end

    // Next state, datapath updates and next registered outputs
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        code_d  = code_q;

        is_req      = (state_q == S_REQ_LEN) || (state_q == S_REQ_DATA) ||
                      (state_q == S_REQ_SUM);
        timeout_hit = TIMEOUT_ON && is_req && !spi_ack &&
                      (cnt_q == CW'(TIMEOUT_CYC - 1));

        case (state_q)
            S_IDLE: state_d = boot_skip ? S_DONE : S_REQ_LEN;
            S_REQ_LEN: begin
                if (spi_ack) begin
                    len_d = spi_rdata;
                    idx_d = '0;
                    sum_d = '0;
                    if (spi_rdata == '0) begin
                        state_d = S_REQ_SUM;
                    end else if (spi_rdata > DW'(MAX_WORDS)) begin
                        state_d = S_ERR;
                        code_d  = 2'd1;
                    end else begin
                        state_d = S_REQ_DATA;
                    end
                end
            end
            S_REQ_DATA: begin
                if (spi_ack) begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                // mem_din_q holds the word being written this cycle
                sum_d   = sum_q ^ mem_din_q;
                idx_d   = idx_q + DW'(1);
                state_d = (idx_d == len_q) ? S_REQ_SUM : S_REQ_DATA;
            end
            S_REQ_SUM: begin
                if (spi_ack) begin
                    if (spi_rdata == sum_q) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ERR;
                        code_d  = 2'd2;
                    end
                end
            end
            default: state_d = state_q;
        endcase

        if (timeout_hit) begin
            state_d = S_ERR;
            code_d  = 2'd3;
        end

        // Wait counter restarts on every ack and on every state entry
        if (TIMEOUT_ON && is_req && !spi_ack && (state_d == state_q)) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = '0;
        end

        // Outputs follow the state being entered so they line up with it
        spi_req_d  = (state_d == S_REQ_LEN) || (state_d == S_REQ_DATA) ||
                     (state_d == S_REQ_SUM);
        mem_wr_d   = (state_d == S_WRITE);
        mem_addr_d = (state_d == S_WRITE) ? LOAD_BASE + ADDR_W'(idx_d) : '0;
        mem_din_d  = (state_d == S_WRITE) ? spi_rdata : '0;
        stall_d    = (state_d != S_DONE);
        done_d     = (state_d == S_DONE);
        err_d      = (state_d == S_ERR);
    end

    // DONE turns the memory port into a combinational CPU pass-through
    assign spi_req   = spi_req_q;
    assign mem_cs    = done_q ? cpu_cs   : mem_wr_q;
    assign mem_we    = done_q ? cpu_we   : mem_wr_q;
    assign mem_addr  = done_q ? cpu_addr : mem_addr_q;
    assign mem_din   = done_q ? cpu_din  : mem_din_q;
    assign cpu_stall = stall_q;
    assign boot_done = done_q;
    assign boot_err  = err_q;
    assign err_code  = code_q;

endmodule

// File: tb/tb_boot_load_ctrl.sv
// Testbench for boot_load_ctrl: a flash responder with random ack latency and
// stray acks, random CPU traffic, and an image-level reference model. The model
// gives the expected write list and the final status of each boot.
module tb_boot_load_ctrl;

    typedef struct packed {
        logic [11:0] addr;
        logic [15:0] data;
    } wr_t;

    logic        clk;
    logic        rst;
    logic        boot_skip;
    logic        spi_req;
    logic        spi_ack;
    logic [15:0] spi_rdata;
    logic        cpu_cs;
    logic        cpu_we;
    logic [11:0] cpu_addr;
    logic [15:0] cpu_din;
    logic        mem_cs;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [15:0] mem_din;
    logic        cpu_stall;
    logic        boot_done;
    logic        boot_err;
    logic [1:0]  err_code;

    boot_load_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .boot_skip (boot_skip),
        .spi_req   (spi_req),
        .spi_ack   (spi_ack),
        .spi_rdata (spi_rdata),
        .cpu_cs    (cpu_cs),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_din   (cpu_din),
        .mem_cs    (mem_cs),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .cpu_stall (cpu_stall),
        .boot_done (boot_done),
        .boot_err  (boot_err),
        .err_code  (err_code)
    );

    int          n_chk = 0;
    int          n_fail = 0;
    bit          chk_en = 0;
    bit          spi_en = 0;
    bit          noise_en = 0;
    bit          cpu_rand = 0;
    int          wait_cnt = 0;
    int          ack_cnt = 0;
    int          req_cycles = 0;
    bit          req_seen = 0;
    bit          prev_wr = 0;

    logic [15:0] feed[$];
    wr_t         exp_writes[$];
    wr_t         seen[$];
    logic [15:0] img[$];
    logic [15:0] img_len;
    logic [15:0] img_sum;
    bit          exp_done;
    logic [1:0]  exp_code;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    // Flash responder and CPU traffic, driven just after each rising edge
    initial begin
        spi_ack   = 1'b0;
        spi_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            spi_ack   = 1'b0;
            spi_rdata = 16'($urandom);
            if (spi_en && spi_req) begin
                if (wait_cnt == 0) begin
                    if (feed.size() > 0) begin
                        spi_ack   = 1'b1;
                        spi_rdata = feed.pop_front();
                        ack_cnt++;
                        wait_cnt  = $urandom_range(0, 3);
                    end
                end else begin
                    wait_cnt--;
                end
            end else if (noise_en && !spi_req) begin
                spi_ack = ($urandom_range(0, 3) == 0);
            end
            if (cpu_rand) begin
                cpu_cs   = 1'($urandom);
                cpu_we   = 1'($urandom);
                cpu_addr = 12'($urandom);
                cpu_din  = 16'($urandom);
            end
        end
    end

    // Per-cycle compare against the image model
    initial begin
        wr_t w;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                if (spi_req) begin
                    req_cycles++;
                    req_seen = 1'b1;
                end
                chk("done_err_exclusive", 32'(boot_done & boot_err), 32'(0));
                if (boot_done) begin
                    chk("pass_cs", 32'(mem_cs), 32'(cpu_cs));
                    chk("pass_we", 32'(mem_we), 32'(cpu_we));
                    chk("pass_addr", 32'(mem_addr), 32'(cpu_addr));
                    chk("pass_din", 32'(mem_din), 32'(cpu_din));
                    chk("done_stall", 32'(cpu_stall), 32'(0));
                    chk("done_spi_req", 32'(spi_req), 32'(0));
                    prev_wr = 1'b0;
                end else begin
                    chk("stall", 32'(cpu_stall), 32'(1));
                    if (mem_cs) begin
                        if (exp_writes.size() == 0) begin
                            chk("unexpected_write", 32'(mem_cs), 32'(0));
                        end else begin
                            w = exp_writes.pop_front();
                            chk("write_we", 32'(mem_we), 32'(1));
                            chk("write_addr", 32'(mem_addr), 32'(w.addr));
                            chk("write_data", 32'(mem_din), 32'(w.data));
                            chk("write_single_cycle", 32'(prev_wr), 32'(0));
                            seen.push_back(wr_t'({mem_addr, mem_din}));
                        end
                    end
                    prev_wr = mem_cs;
                end
            end
        end
    end

    // Image-level model: SPI word stream, expected writes and final status
    task automatic build_model();
        logic [15:0] x;
        x = '0;
        feed.delete();
        exp_writes.delete();
        feed.push_back(img_len);
        if (img_len > 16'd256) begin
            exp_done = 1'b0;
            exp_code = 2'd1;
        end else begin
            for (int i = 0; i < int'(img_len); i++) begin
                feed.push_back(img[i]);
                exp_writes.push_back(wr_t'({12'(12'h010 + i), img[i]}));
                x = x ^ img[i];
            end
            feed.push_back(img_sum);
            exp_done = (img_sum == x);
            exp_code = exp_done ? 2'd0 : 2'd2;
        end
    endtask

    // Hold reset for one edge, check reset values, leave reset asserted
    task automatic apply_reset();
        @(posedge clk);
        #1;
        rst    = 1'b0;
        spi_en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        feed.delete();
        exp_writes.delete();
        seen.delete();
        wait_cnt   = 0;
        ack_cnt    = 0;
        req_cycles = 0;
        req_seen   = 1'b0;
        prev_wr    = 1'b0;
        if (chk_en) begin
            chk("rst_spi_req", 32'(spi_req), 32'(0));
            chk("rst_mem_cs", 32'(mem_cs), 32'(0));
            chk("rst_mem_we", 32'(mem_we), 32'(0));
            chk("rst_mem_addr", 32'(mem_addr), 32'(0));
            chk("rst_mem_din", 32'(mem_din), 32'(0));
            chk("rst_stall", 32'(cpu_stall), 32'(1));
            chk("rst_done", 32'(boot_done), 32'(0));
            chk("rst_err", 32'(boot_err), 32'(0));
            chk("rst_code", 32'(err_code), 32'(0));
        end
    endtask

    task automatic release_reset(input bit en);
        @(posedge clk);
        #1;
        rst    = 1'b1;
        spi_en = en;
    endtask

    task automatic run_image(input int budget);
        int cyc;
        apply_reset();
        build_model();
        release_reset(1'b1);
        cyc = 0;
        while (!(boot_done || boot_err) && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        chk("boot_finished", 32'(boot_done | boot_err), 32'(1));
        repeat (12) @(negedge clk);
        chk("end_done", 32'(boot_done), 32'(exp_done));
        chk("end_err", 32'(boot_err), 32'(!exp_done));
        chk("end_code", 32'(err_code), 32'(exp_code));
        chk("end_stall", 32'(cpu_stall), 32'(!exp_done));
        chk("writes_left", 32'(exp_writes.size()), 32'(0));
        chk("words_left", 32'(feed.size()), 32'(0));
    endtask

    initial begin
        int          cyc;
        int          sel;
        logic [15:0] x;
        rst       = 1'b0;
        boot_skip = 1'b0;
        cpu_cs    = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_din   = '0;

        apply_reset();
        chk_en = 1'b1;
        apply_reset();

        // boot_skip: CPU visible on memory port within two cycles
        boot_skip = 1'b1;
        cpu_cs    = 1'b1;
        cpu_we    = 1'b0;
        cpu_addr  = 12'h123;
        cpu_din   = 16'hbeef;
        release_reset(1'b0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("skip_done", 32'(boot_done), 32'(1));
        chk("skip_stall", 32'(cpu_stall), 32'(0));
        chk("skip_cs", 32'(mem_cs), 32'(1));
        chk("skip_we", 32'(mem_we), 32'(0));
        chk("skip_addr", 32'(mem_addr), 32'(12'h123));
        chk("skip_din", 32'(mem_din), 32'(16'hbeef));
        chk("skip_no_req", 32'(req_seen), 32'(0));
        boot_skip = 1'b0;
        cpu_rand  = 1'b1;
        noise_en  = 1'b1;

        // Good three-word image
        img = '{16'h1111, 16'h2222, 16'h4444};
        img_len = 16'd3;
        img_sum = 16'h7777;
        run_image(200);
        chk("lit_good_nwr", 32'(seen.size()), 32'(3));
        if (seen.size() == 3) begin
            chk("lit_w0", 32'(seen[0]), {4'h0, 12'h010, 16'h1111});
            chk("lit_w1", 32'(seen[1]), {4'h0, 12'h011, 16'h2222});
            chk("lit_w2", 32'(seen[2]), {4'h0, 12'h012, 16'h4444});
        end
        chk("lit_good_done", 32'(boot_done), 32'(1));

        // Same image, wrong checksum
        img_sum = 16'h7776;
        run_image(200);
        chk("lit_bad_err", 32'(boot_err), 32'(1));
        chk("lit_bad_code", 32'(err_code), 32'(2));
        chk("lit_bad_stall", 32'(cpu_stall), 32'(1));
        chk("lit_bad_nwr", 32'(seen.size()), 32'(3));

        // Oversized length
        img_len = 16'h0101;
        run_image(100);
        chk("lit_len_code", 32'(err_code), 32'(1));
        chk("lit_len_nwr", 32'(seen.size()), 32'(0));
        chk("lit_len_acks", 32'(ack_cnt), 32'(1));

        // Reset during the second data word, then a full reload
        img = '{16'hA5A5, 16'h0F0F, 16'h1234, 16'hFFFF};
        img_len = 16'd4;
        x = 16'hA5A5 ^ 16'h0F0F ^ 16'h1234 ^ 16'hFFFF;
        img_sum = x;
        apply_reset();
        build_model();
        release_reset(1'b1);
        cyc = 0;
        while (ack_cnt < 2 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("midload_progress", 32'(ack_cnt), 32'(2));
        repeat (3) @(negedge clk);
        run_image(200);
        chk("reload_nwr", 32'(seen.size()), 32'(4));
        if (seen.size() == 4) begin
            chk("reload_w0", 32'(seen[0]), {4'h0, 12'h010, 16'hA5A5});
        end

        // Random images
        for (int t = 0; t < 40; t++) begin
            sel = $urandom_range(0, 9);
            if (sel < 8) img_len = 16'($urandom_range(0, 12));
            else if (sel == 8) img_len = 16'($urandom_range(250, 256));
            else img_len = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(257, 300)) : 16'hFFFF;
            img.delete();
            x = '0;
            if (img_len <= 16'd256) begin
                for (int i = 0; i < int'(img_len); i++) begin
                    img.push_back(16'($urandom));
                    x = x ^ img[i];
                end
            end
            img_sum = ($urandom_range(0, 9) < 7) ? x : (x ^ 16'(1 << $urandom_range(0, 15)));
            run_image(int'(img_len) * 6 + 60);
        end

`ifdef BOOT_TIMEOUT_EN
        // No flash answer at all: timeout after 1023 request cycles
        img.delete();
        img_len = 16'd2;
        img = '{16'h0001, 16'h0002};
        img_sum = 16'h0003;
        apply_reset();
        build_model();
        release_reset(1'b0);
        cyc = 0;
        while (!boot_err && cyc < 1200) begin
            @(negedge clk);
            cyc++;
        end
        repeat (3) @(negedge clk);
        chk("to_err", 32'(boot_err), 32'(1));
        chk("to_code", 32'(err_code), 32'(3));
        chk("to_req_cycles", 32'(req_cycles), 32'(1023));
        chk("to_req_low", 32'(spi_req), 32'(0));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
